// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry instruction prefetch queue with opcode/operand split head, flush and sticky overflow.
// Optional same-cycle bypass from `in_i` to the head is enabled by defining IR_QUEUE_BYPASS_EN.
module ir_queue #(
   parameter int WORD_W   = 8,
   parameter int OPCODE_W = 3,
   parameter int DEPTH    = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        flush_i,
   input  logic                        we_i,
   input  logic [WORD_W-1:0]           in_i,
   input  logic                        advance_i,
   output logic                        full_o,
   output logic                        out_valid_o,
   output logic [OPCODE_W-1:0]         out_opcode_o,
   output logic [WORD_W-OPCODE_W-1:0]  out_operand_o,
   output logic [$clog2(DEPTH):0]      count_o,
   output logic                        err_ovf_o
);
   localparam int OPERAND_W = WORD_W - OPCODE_W;
   localparam int CNT_W     = $clog2(DEPTH) + 1;
   localparam int PTR_W     = $clog2(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              err_ovf_q, err_ovf_d;

   logic              empty_s, full_s, pop_s, push_s, drop_s, bypass_take_s;
   logic              valid_s;
   logic [WORD_W-1:0] word_s;

   assign empty_s = (count_q == '0);
   assign full_s  = (count_q == CNT_W'(DEPTH));

`ifdef IR_QUEUE_BYPASS_EN
   // A bypassed word consumed in the same cycle never touches storage.
   assign bypass_take_s = empty_s && we_i && advance_i && !flush_i;
`else
   assign bypass_take_s = 1'b0;
`endif

   assign pop_s  = advance_i && !empty_s && !flush_i;
   assign push_s = we_i && (!full_s || pop_s) && !flush_i && !bypass_take_s;
   assign drop_s = we_i && !push_s && !bypass_take_s && !flush_i;

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      err_ovf_d = err_ovf_q;
      if (flush_i) begin
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         count_d   = '0;
         err_ovf_d = 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (drop_s) begin
            err_ovf_d = 1'b1;
         end else begin
            err_ovf_d = err_ovf_q;
         end
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         err_ovf_q <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         err_ovf_q <= err_ovf_d;
      end
   end

   // Word storage; contents are don't-care after reset so it carries none.
   always_ff @(posedge clk_i) begin
      if (push_s && !rst_i) begin
         mem_q[wr_ptr_q] <= in_i;
      end
   end

   // Head selection and field split; fields are forced to zero while invalid.
   always_comb begin
      valid_s = !empty_s;
      word_s  = mem_q[rd_ptr_q];
`ifdef IR_QUEUE_BYPASS_EN
      if (empty_s && we_i && !flush_i) begin
         valid_s = 1'b1;
         word_s  = in_i;
      end else begin
         valid_s = !empty_s;
         word_s  = mem_q[rd_ptr_q];
      end
`endif
      if (valid_s) begin
         out_opcode_o  = word_s[WORD_W-1 -: OPCODE_W];
         out_operand_o = word_s[OPERAND_W-1:0];
      end else begin
         out_opcode_o  = '0;
         out_operand_o = '0;
      end
   end

   assign out_valid_o = valid_s;
   assign full_o      = full_s;
   assign count_o     = count_q;
   assign err_ovf_o   = err_ovf_q;

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: scoreboard queue of expected head words, one task per scenario.
module tb_ir_queue;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst, flush, we, advance;
   logic [7:0] din;
   logic       full, out_valid, err_ovf;
   logic [2:0] out_opcode;
   logic [4:0] out_operand;
   logic [2:0] count;

   logic [7:0] sb[$];
   logic       exp_err;
   int         checks = 0;
   int         passed = 0;

   ir_queue #(.WORD_W(8), .OPCODE_W(3), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .we_i(we), .in_i(din),
      .advance_i(advance), .full_o(full), .out_valid_o(out_valid),
      .out_opcode_o(out_opcode), .out_operand_o(out_operand),
      .count_o(count), .err_ovf_o(err_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Drive one cycle of stimulus and advance the reference model across the edge.
   task automatic drive(input logic w, input logic [7:0] d, input logic a, input logic f);
      bit pop, push, byp;
      we = w; din = d; advance = a; flush = f;
      #2;
      if (f) begin
         sb.delete();
         exp_err = 1'b0;
      end else begin
         pop = a && (sb.size() > 0);
`ifdef IR_QUEUE_BYPASS_EN
         byp = (sb.size() == 0) && w && a;
`else
         byp = 1'b0;
`endif
         push = w && ((sb.size() < DEPTH) || pop) && !byp;
         if (pop) sb.delete(0);
         if (push) sb.push_back(d);
         if (w && !push && !byp) exp_err = 1'b1;
      end
      @(posedge clk); #1;
      we = 1'b0; advance = 1'b0; flush = 1'b0; din = 8'h00;
   endtask

   task automatic test_reset();
      rst = 1'b1; we = 1'b1; din = 8'hEE; advance = 1'b1; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; we = 1'b0; advance = 1'b0; din = 8'h00;
      sb.delete(); exp_err = 1'b0;
      checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
      checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
      checks++; if (err_ovf !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_ovf); else passed++;
      checks++; if ({out_opcode, out_operand} !== 8'h00) $display("FAIL reset_head: got %h expected 00", {out_opcode, out_operand}); else passed++;
   endtask

   task automatic test_fill();
      logic [7:0] words [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, words[i], 1'b0, 1'b0);
         checks++; if (count !== 3'(sb.size())) $display("FAIL fill_count: got %0d expected %0d", count, sb.size()); else passed++;
         checks++; if (full !== (i == 3)) $display("FAIL fill_full: got %b expected %b", full, (i == 3)); else passed++;
         checks++; if (out_opcode !== 3'b101 || out_operand !== 5'b00101) $display("FAIL fill_head: got %b/%b expected 101/00101", out_opcode, out_operand); else passed++;
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_valid !== 1'b1 || {out_opcode, out_operand} !== sb[0]) $display("FAIL drain_head: got %b %h expected 1 %h", out_valid, {out_opcode, out_operand}, sb[0]); else passed++;
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         checks++; if (count !== 3'(sb.size())) $display("FAIL drain_count: got %0d expected %0d", count, sb.size()); else passed++;
      end
      checks++; if (out_valid !== 1'b0) $display("FAIL drain_empty_valid: got %b expected 0", out_valid); else passed++;
      checks++; if ({out_opcode, out_operand} !== 8'h00) $display("FAIL drain_empty_head: got %h expected 00", {out_opcode, out_operand}); else passed++;
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (count !== 3'd0) $display("FAIL extra_adv_count: got %0d expected 0", count); else passed++;
      checks++; if (err_ovf !== 1'b0) $display("FAIL extra_adv_err: got %b expected 0", err_ovf); else passed++;
   endtask

   task automatic test_full_simul();
      logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] last;
      for (int i = 0; i < 4; i++) drive(1'b1, words[i], 1'b0, 1'b0);
      drive(1'b1, 8'h77, 1'b1, 1'b0);
      checks++; if (count !== 3'd4 || full !== 1'b1) $display("FAIL simul_count: got %0d/%b expected 4/1", count, full); else passed++;
      checks++; if (err_ovf !== 1'b0) $display("FAIL simul_err: got %b expected 0", err_ovf); else passed++;
      drive(1'b1, 8'h88, 1'b0, 1'b0);
      checks++; if (err_ovf !== exp_err || exp_err !== 1'b1) $display("FAIL drop_err: got %b expected 1", err_ovf); else passed++;
      checks++; if (count !== 3'd4) $display("FAIL drop_count: got %0d expected 4", count); else passed++;
      last = 8'h00;
      for (int i = 0; i < 4; i++) begin
         checks++; if ({out_opcode, out_operand} !== sb[0]) $display("FAIL simul_order: got %h expected %h", {out_opcode, out_operand}, sb[0]); else passed++;
         last = {out_opcode, out_operand};
         drive(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checks++; if (last !== 8'h77) $display("FAIL simul_last: got %h expected 77", last); else passed++;
      checks++; if (err_ovf !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err_ovf); else passed++;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) drive(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
      checks++; if (count !== 3'd3) $display("FAIL preflush_count: got %0d expected 3", count); else passed++;
      drive(1'b1, 8'h77, 1'b1, 1'b1);
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL flush_state: got %0d/%b expected 0/0", count, out_valid); else passed++;
      checks++; if (err_ovf !== 1'b0) $display("FAIL flush_err: got %b expected 0", err_ovf); else passed++;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0 || {out_opcode, out_operand} === 8'h77) $display("FAIL flush_no77: got %b %h expected 0 00", out_valid, {out_opcode, out_operand}); else passed++;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
         checks++; if (count !== 3'd1) $display("FAIL wrap_count: got %0d expected 1", count); else passed++;
         checks++; if ({out_opcode, out_operand} !== 8'h10 + 8'(i)) $display("FAIL wrap_head: got %h expected %h", {out_opcode, out_operand}, 8'h10 + 8'(i)); else passed++;
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         checks++; if (count !== 3'(sb.size())) $display("FAIL wrap_pop_count: got %0d expected %0d", count, sb.size()); else passed++;
      end
   endtask

   task automatic test_bypass();
      we = 1'b1; din = 8'h42; advance = 1'b1; flush = 1'b0;
      #2;
`ifdef IR_QUEUE_BYPASS_EN
      checks++; if (out_valid !== 1'b1 || out_opcode !== 3'b010) $display("FAIL bypass_same: got %b/%b expected 1/010", out_valid, out_opcode); else passed++;
`else
      checks++; if (out_valid !== 1'b0) $display("FAIL nobypass_same: got %b expected 0", out_valid); else passed++;
      sb.push_back(8'h42);
`endif
      @(posedge clk); #1;
      we = 1'b0; advance = 1'b0; din = 8'h00;
`ifdef IR_QUEUE_BYPASS_EN
      checks++; if (count !== 3'd0) $display("FAIL bypass_count: got %0d expected 0", count); else passed++;
`else
      checks++; if (count !== 3'd1 || out_valid !== 1'b1 || out_opcode !== 3'b010) $display("FAIL nobypass_next: got %0d/%b/%b expected 1/1/010", count, out_valid, out_opcode); else passed++;
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (count !== 3'd0) $display("FAIL nobypass_drain: got %0d expected 0", count); else passed++;
`endif
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; we = 1'b0; advance = 1'b0; din = 8'h00; exp_err = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_fill();
      test_drain();
      test_full_simul();
      test_flush();
      test_wrap();
      test_bypass();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised instruction register successor: a DEPTH-entry prefetch queue of instruction words between instruction memory fetch and the control unit.
- Head entry is presented pre-split into opcode and operand fields.
- Adds fill/drain handshake, flush on branch, occupancy count and a sticky overflow flag, replacing the single 8-bit latch.

Parameters:
- WORD_W, 8, instruction word width in bits (>= OPCODE_W+1).
- OPCODE_W, 3, opcode field width; the opcode is the MSBs of the word. OPERAND_W = WORD_W-OPCODE_W (derived localparam).
- DEPTH, 4, number of queue entries; power of two, >= 2. CNT_W = clog2(DEPTH)+1 (derived).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all queued words (branch taken)
- we  in  1  write request; offers `in` for enqueue
- in  in  WORD_W  instruction word from memory
- advance  in  1  control unit consumes the head entry
- full  out  1  queue holds DEPTH entries
- out_valid  out  1  head entry valid
- out_opcode  out  OPCODE_W  head word[WORD_W-1 -: OPCODE_W]
- out_operand  out  OPERAND_W  head word[OPERAND_W-1:0]
- count  out  CNT_W  occupancy, 0..DEPTH
- err_ovf  out  1  sticky: a write was dropped

Behaviour:
- Reset (sync, rst=1 at posedge): rd/wr pointers=0, count=0, full=0, out_valid=0, err_ovf=0. Storage contents are don't-care. rst overrides all other inputs.
- out_valid = (count != 0). full = (count == DEPTH).
- When out_valid=0, out_opcode and out_operand are driven to 0, never stale data.
- pop = advance && out_valid. advance while empty is ignored and does not set an error.
- push = we && (!full || pop). A write into a full queue is accepted only when a pop occurs in the same cycle.
- Dropped write (we && !push && !flush) sets err_ovf on the next edge. err_ovf is cleared only by rst or flush.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count saturates structurally at DEPTH; it is never incremented past DEPTH or decremented below 0.
- Write latency: a word pushed at edge N is visible at the head after edge N when the queue was empty. Otherwise it is visible after all older entries drain.
- FIFO order is strictly preserved.
- flush has priority over we and advance in the same cycle: pointers=0, count=0, err_ovf=0, and the word offered that cycle is dropped without flagging. out_valid=0 from the next cycle.
- No internal state machine beyond pointers/count. All outputs except the head fields (combinational from storage and rd pointer) are registered or derived from registered count.

Optional Feature:
- Macro IR_QUEUE_BYPASS_EN.
- Defined: when count=0 and we=1 (and no flush), out_valid=1 combinationally in the same cycle, with out_opcode/out_operand taken from `in`.
  - If advance=1 in that cycle, the word is consumed and not stored; count stays 0.
  - If advance=0, the word is stored normally.
  - full and count remain registered and are unaffected by the bypass path.
- Undefined: no combinational path from `in`/we to the outputs; minimum enqueue-to-head latency is one cycle as above.

Test Plan:
- Reset/fill: rst, then write 0xA5, 0x3C, 0xFF, 0x01 (DEPTH=4) -> count 1..4, full=1 after the 4th; head out_opcode=3'b101, out_operand=5'b00101.
- Drain order: pulse advance four times -> heads 0xA5, 0x3C, 0xFF, 0x01 in order; then out_valid=0, outputs 0, count=0. Extra advance -> no change, err_ovf=0.
- Full + simultaneous: full queue, we=1 in=0x77 with advance=1 -> count stays 4, 0x77 becomes the last entry. Next cycle, we=1 without advance -> write dropped, err_ovf=1.
- Flush priority: count=3, flush=1 with we=1 and advance=1 -> next cycle count=0, out_valid=0, err_ovf=0; 0x77 never appears at the head.
- Wrap-around: 10 interleaved push/pop pairs with words 0x10..0x19 -> pointers wrap, output order preserved, count never exceeds 1.
- Bypass (IR_QUEUE_BYPASS_EN defined): empty queue, we=1 in=0x42 advance=1 -> out_valid=1 and out_opcode=3'b010 in the same cycle; next cycle count=0. With the macro undefined -> out_valid=0 that cycle, then 1 next cycle with count=1.
